// File: rtl/l1d_mshr_alloc.sv
// L1D MSHR entry allocator: tracks free entries in a bit vector and offers the lowest
// free index through a registered one-entry stage; retired entries return via release.
`ifndef L1D_MSHR_ID_WIDTH
`define L1D_MSHR_ID_WIDTH 3
`endif

module l1d_mshr_alloc #(
    parameter int ENTRY_NUM = 8,
    parameter int ID_WIDTH  = `L1D_MSHR_ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                alloc_vld,
    input  logic                alloc_rdy,
    output logic [ID_WIDTH-1:0] alloc_index,
    input  logic                release_vld,
    input  logic [ID_WIDTH-1:0] release_index,
    output logic [ID_WIDTH:0]   free_cnt,
    output logic                full,
    output logic                release_err
);

    logic [ENTRY_NUM-1:0] free_reg;
    logic [ENTRY_NUM-1:0] free_next;
    logic                 alloc_vld_reg;
    logic                 alloc_vld_next;
    logic [ID_WIDTH-1:0]  alloc_index_reg;
    logic [ID_WIDTH-1:0]  alloc_index_next;
    logic [ID_WIDTH:0]    free_cnt_reg;
    logic [ID_WIDTH:0]    free_cnt_next;
    logic                 release_err_reg;
    logic                 release_err_next;

    logic [ENTRY_NUM-1:0] rel_hit;
    logic [ENTRY_NUM-1:0] pick_oh;
    logic [ID_WIDTH-1:0]  pick_idx;
    logic                 pick_any;
    logic                 transfer;
    logic                 load;
    logic                 rel_legal;

    // Out-of-range indices decode to no hit, which makes them illegal automatically.
    generate
        for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_decode
            assign rel_hit[gi] = release_vld && (release_index == ID_WIDTH'(gi));
            assign pick_oh[gi] = pick_any && (pick_idx == ID_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        pick_idx = '0;
        pick_any = 1'b0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (free_reg[i]) begin
                pick_idx = ID_WIDTH'(i);
                pick_any = 1'b1;
            end
        end
    end

    assign transfer  = alloc_vld_reg && alloc_rdy;
    assign load      = !alloc_vld_reg || alloc_rdy;
    // The staged index stays illegal to release even while it is transferring.
    assign rel_legal = (|rel_hit) && !(|(rel_hit & free_reg))
                       && !(alloc_vld_reg && (alloc_index_reg == release_index));

    always_comb begin
        free_next        = free_reg;
        alloc_vld_next   = alloc_vld_reg;
        alloc_index_next = alloc_index_reg;
        free_cnt_next    = free_cnt_reg + (ID_WIDTH+1)'(rel_legal) - (ID_WIDTH+1)'(transfer);
        release_err_next = release_vld && !rel_legal;
        if (rel_legal) begin
            free_next = free_next | rel_hit;
        end
        if (load) begin
            alloc_vld_next = pick_any;
            if (pick_any) begin
                alloc_index_next = pick_idx;
                free_next        = free_next & ~pick_oh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_reg        <= '1;
            alloc_vld_reg   <= 1'b0;
            alloc_index_reg <= '0;
            free_cnt_reg    <= (ID_WIDTH+1)'(ENTRY_NUM);
            release_err_reg <= 1'b0;
        end else begin
            free_reg        <= free_next;
            alloc_vld_reg   <= alloc_vld_next;
            alloc_index_reg <= alloc_index_next;
            free_cnt_reg    <= free_cnt_next;
            release_err_reg <= release_err_next;
        end
    end

    assign alloc_vld   = alloc_vld_reg;
    assign alloc_index = alloc_index_reg;
    assign free_cnt    = free_cnt_reg;
    assign full        = (free_cnt_reg == '0);
    assign release_err = release_err_reg;

endmodule

// File: tb/tb_l1d_mshr_alloc.sv
// Directed bench for l1d_mshr_alloc with ENTRY_NUM=4; a second, wider-index instance
// exercises the out-of-range release case.
module tb_l1d_mshr_alloc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_vld;
    logic       alloc_rdy = 1'b0;
    logic [1:0] alloc_index;
    logic       release_vld = 1'b0;
    logic [1:0] release_index = '0;
    logic [2:0] free_cnt;
    logic       full;
    logic       release_err;

    logic       w_alloc_vld;
    logic [2:0] w_alloc_index;
    logic       w_release_vld = 1'b0;
    logic [2:0] w_release_index = '0;
    logic [3:0] w_free_cnt;
    logic       w_full;
    logic       w_release_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l1d_mshr_alloc #(.ENTRY_NUM(4), .ID_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_index(alloc_index),
        .release_vld(release_vld), .release_index(release_index),
        .free_cnt(free_cnt), .full(full), .release_err(release_err)
    );

    l1d_mshr_alloc #(.ENTRY_NUM(4), .ID_WIDTH(3)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(w_alloc_vld), .alloc_rdy(1'b0), .alloc_index(w_alloc_index),
        .release_vld(w_release_vld), .release_index(w_release_index),
        .free_cnt(w_free_cnt), .full(w_full), .release_err(w_release_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic vld, input logic [1:0] idx,
                              input logic [2:0] cnt, input logic fl, input logic err);
        chk({tag, ".vld"}, 32'(alloc_vld), 32'(vld));
        if (vld) chk({tag, ".idx"}, 32'(alloc_index), 32'(idx));
        chk({tag, ".cnt"}, 32'(free_cnt), 32'(cnt));
        chk({tag, ".full"}, 32'(full), 32'(fl));
        chk({tag, ".err"}, 32'(release_err), 32'(err));
        $display("t=%0t %s vld=%0b idx=%0d cnt=%0d full=%0b err=%0b",
                 $time, tag, alloc_vld, alloc_index, free_cnt, full, release_err);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rel(input logic v, input logic [1:0] idx);
        release_vld   = v;
        release_index = idx;
    endtask

    initial begin
        // Reset state
        alloc_rdy = 1'b1;
        step();
        chk("rst.idx", 32'(alloc_index), 32'd0);
        expect_out("rst", 1'b0, 2'd0, 3'd4, 1'b0, 1'b0);

        // Back-to-back allocation after reset
        rst_n = 1'b1;
        step();
        expect_out("c1", 1'b1, 2'd0, 3'd4, 1'b0, 1'b0);
        w_release_vld = 1'b1; w_release_index = 3'd5;
        step();
        expect_out("c2", 1'b1, 2'd1, 3'd3, 1'b0, 1'b0);
        chk("w.err5", 32'(w_release_err), 32'd1);
        chk("w.cnt5", 32'(w_free_cnt), 32'd4);
        chk("w.idx5", 32'(w_alloc_index), 32'd0);
        w_release_vld = 1'b0;
        step();
        expect_out("c3", 1'b1, 2'd2, 3'd2, 1'b0, 1'b0);
        chk("w.err_clr", 32'(w_release_err), 32'd0);
        step();
        expect_out("c4", 1'b1, 2'd3, 3'd1, 1'b0, 1'b0);
        step();
        expect_out("c5", 1'b0, 2'd0, 3'd0, 1'b1, 1'b0);

        // Release from full: counted at t, offered after t+1
        rel(1'b1, 2'd2);
        step();
        expect_out("rel2_t", 1'b0, 2'd0, 3'd1, 1'b0, 1'b0);
        rel(1'b0, 2'd0); alloc_rdy = 1'b0;
        step();
        expect_out("rel2_t1", 1'b1, 2'd2, 3'd1, 1'b0, 1'b0);

        // Releasing the staged index is illegal
        rel(1'b1, 2'd2);
        step();
        expect_out("err_staged", 1'b1, 2'd2, 3'd1, 1'b0, 1'b1);
        rel(1'b0, 2'd0);
        step();
        expect_out("err_pulse", 1'b1, 2'd2, 3'd1, 1'b0, 1'b0);

        // Stage index 3, then transfer it while releasing 0
        rel(1'b1, 2'd3);
        step();
        expect_out("rel3", 1'b1, 2'd2, 3'd2, 1'b0, 1'b0);
        rel(1'b0, 2'd0); alloc_rdy = 1'b1;
        step();
        expect_out("stage3", 1'b1, 2'd3, 3'd1, 1'b0, 1'b0);
        rel(1'b1, 2'd0);
        step();
        expect_out("xfer3_rel0", 1'b0, 2'd0, 3'd1, 1'b0, 1'b0);
        rel(1'b0, 2'd0); alloc_rdy = 1'b0;
        step();
        expect_out("stage0", 1'b1, 2'd0, 3'd1, 1'b0, 1'b0);

        // Already-free release is illegal
        rel(1'b1, 2'd1);
        step();
        expect_out("rel1", 1'b1, 2'd0, 3'd2, 1'b0, 1'b0);
        step();
        expect_out("err_free", 1'b1, 2'd0, 3'd2, 1'b0, 1'b1);

        // Staged index holds while a lower one is released
        rel(1'b0, 2'd0); alloc_rdy = 1'b1;
        step();
        expect_out("stage1", 1'b1, 2'd1, 3'd1, 1'b0, 1'b0);
        rel(1'b1, 2'd0); alloc_rdy = 1'b0;
        step();
        expect_out("hold1_a", 1'b1, 2'd1, 3'd2, 1'b0, 1'b0);
        rel(1'b0, 2'd0);
        step();
        expect_out("hold1_b", 1'b1, 2'd1, 3'd2, 1'b0, 1'b0);
        alloc_rdy = 1'b1;
        step();
        expect_out("next0", 1'b1, 2'd0, 3'd1, 1'b0, 1'b0);

        // Index 3 was allocated by the earlier transfer, so releasing it is legal
        alloc_rdy = 1'b0; rel(1'b1, 2'd3);
        step();
        expect_out("rel3_legal", 1'b1, 2'd0, 3'd2, 1'b0, 1'b0);

        // Release of the transferring index: error, transfer still completes
        alloc_rdy = 1'b1; rel(1'b1, 2'd0);
        step();
        expect_out("xfer_rel_same", 1'b1, 2'd3, 3'd1, 1'b0, 1'b1);
        rel(1'b0, 2'd0);

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 2'd0, 3'd4, 1'b0, 1'b0);
        chk("async_rst.idx", 32'(alloc_index), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        expect_out("r1", 1'b1, 2'd0, 3'd4, 1'b0, 1'b0);
        step();
        expect_out("r2", 1'b1, 2'd1, 3'd3, 1'b0, 1'b0);
        step();
        expect_out("r3", 1'b1, 2'd2, 3'd2, 1'b0, 1'b0);
        step();
        expect_out("r4", 1'b1, 2'd3, 3'd1, 1'b0, 1'b0);
        step();
        expect_out("r5", 1'b0, 2'd0, 3'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
